// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table, mode encoding, gain.
// Used by the iterative engine and the unrolled pipeline.
package cordic_pkg;

  localparam int ATAN_DEPTH = 32;
  localparam int ATAN_LUT_W = 32;

  localparam real CORDIC_GAIN = 1.6467602581;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  // atan(2^-i) with 2^32 == 2*pi
  function automatic logic [ATAN_LUT_W-1:0] atan_lut(
    input int unsigned i
  );
    logic [ATAN_LUT_W-1:0] v;
    case (i)
      0:  v = 32'd536870912;
      1:  v = 32'd316933406;
      2:  v = 32'd167458907;
      3:  v = 32'd85004756;
      4:  v = 32'd42667331;
      5:  v = 32'd21354465;
      6:  v = 32'd10679838;
      7:  v = 32'd5340245;
      8:  v = 32'd2670163;
      9:  v = 32'd1335087;
      10: v = 32'd667544;
      11: v = 32'd333772;
      12: v = 32'd166886;
      13: v = 32'd83443;
      14: v = 32'd41722;
      15: v = 32'd20861;
      16: v = 32'd10430;
      17: v = 32'd5215;
      18: v = 32'd2608;
      19: v = 32'd1304;
      20: v = 32'd652;
      21: v = 32'd326;
      22: v = 32'd163;
      23: v = 32'd81;
      24: v = 32'd41;
      25: v = 32'd20;
      26: v = 32'd10;
      27: v = 32'd5;
      28: v = 32'd3;
      29: v = 32'd1;
      30: v = 32'd1;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation step.
// Shared between the iterative engine and the unrolled pipeline.
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int XW  = 20,
  parameter int ZW  = 32,
  parameter int SHW = 5
) (
  input  logic signed [XW-1:0]  i_x,
  input  logic signed [XW-1:0]  i_y,
  input  logic signed [ZW-1:0]  i_z,
  input  logic        [SHW-1:0] i_shift,
  input  logic signed [ZW-1:0]  i_atan,
  input  cordic_mode_e          i_mode,
  output logic signed [XW-1:0]  o_x,
  output logic signed [XW-1:0]  o_y,
  output logic signed [ZW-1:0]  o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic                 w_ccw;

  assign w_xs = i_x >>> i_shift;
  assign w_ys = i_y >>> i_shift;

  // ccw: rotate towards z=0 (rotation) or y=0 (vectoring)
  assign w_ccw = (i_mode == MODE_VEC) ? i_y[XW-1] : ~i_z[ZW-1];

  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (w_ccw) begin
      o_x = i_x - w_ys;
      o_y = i_y + w_xs;
      o_z = i_z - i_atan;
    end else begin
      o_x = i_x + w_ys;
      o_y = i_y - w_xs;
      o_z = i_z + i_atan;
    end
  end

endmodule

// File: rtl/cordic_iterative.sv
// Folded CORDIC engine: one micro-rotation per cycle, NITER cycles
// per operand set, valid/ready on both sides.
module cordic_iterative
  import cordic_pkg::*;
#(
  parameter int XYI     = 19,
  parameter int ANGLE_W = 32,
  parameter int NITER   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_mode,
  input  logic signed [XYI:0]       x_in,
  input  logic signed [XYI:0]       y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [XYI:0]       x_out,
  output logic signed [XYI:0]       y_out,
  output logic signed [ANGLE_W-1:0] z_out,
  output logic                      busy
);

  localparam int XW = XYI + 1;
  localparam int CW = $clog2(NITER + 1);

  if (NITER < 1 || NITER > XW || NITER > ATAN_DEPTH) begin : g_bad_niter
    $error("cordic_iterative: NITER out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic [CW-1:0]             r_i;
  cordic_mode_e              r_mode;
  logic signed [XW-1:0]      r_x;
  logic signed [XW-1:0]      r_y;
  logic signed [ANGLE_W-1:0] r_z;

  logic                      w_accept;
  logic                      w_last;
  logic [ATAN_LUT_W-1:0]     w_atan_raw;
  logic signed [ANGLE_W-1:0] w_atan;
  logic signed [XW-1:0]      w_x_nxt;
  logic signed [XW-1:0]      w_y_nxt;
  logic signed [ANGLE_W-1:0] w_z_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_i == CW'(NITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_atan_raw = atan_lut(32'(r_i));

  // table is 32-bit; rescale to the configured angle width
  if (ANGLE_W == ATAN_LUT_W) begin : g_atan_eq
    assign w_atan = w_atan_raw;
  end else if (ANGLE_W > ATAN_LUT_W) begin : g_atan_wide
    assign w_atan = {w_atan_raw, {(ANGLE_W-ATAN_LUT_W){1'b0}}};
  end else begin : g_atan_narrow
    assign w_atan = w_atan_raw[ATAN_LUT_W-1 -: ANGLE_W];
  end

  cordic_microrot #(
    .XW  (XW),
    .ZW  (ANGLE_W),
    .SHW (CW)
  ) u_microrot (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_i),
    .i_atan  (w_atan),
    .i_mode  (r_mode),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i    <= '0;
      r_mode <= MODE_ROT;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
    end else if (w_accept) begin
      r_i    <= '0;
      r_mode <= cordic_mode_e'(in_mode);
      r_x    <= x_in;
      r_y    <= y_in;
      r_z    <= z_in;
    end else if (r_state == S_RUN) begin
      r_i    <= r_i + 1'b1;
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_z    <= w_z_nxt;
    end
  end

  assign x_out = r_x;
  assign y_out = r_y;
  assign z_out = r_z;

endmodule

// File: tb/tb_cordic_iterative.sv
// Directed bench for cordic_iterative: vector table plus
// back-pressure, back-to-back and mid-run reset sequences.
module tb_cordic_iterative;
  import cordic_pkg::*;

  localparam int XYI     = 19;
  localparam int ANGLE_W = 32;
  localparam int NITER   = 16;
  localparam int TMO     = 200;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      in_mode = 1'b0;
  logic signed [XYI:0]       x_in = '0;
  logic signed [XYI:0]       y_in = '0;
  logic signed [ANGLE_W-1:0] z_in = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic signed [XYI:0]       x_out;
  logic signed [XYI:0]       y_out;
  logic signed [ANGLE_W-1:0] z_out;
  logic                      busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_iterative #(
    .XYI(XYI), .ANGLE_W(ANGLE_W), .NITER(NITER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .busy(busy)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp, input longint tol);
    longint d;
    checks++;
    d = act - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (tol %0d)",
               nm, act, exp, tol);
    end
  endtask

  function automatic void ref_model(
    input  logic                      m,
    input  logic signed [XYI:0]       xi,
    input  logic signed [XYI:0]       yi,
    input  logic signed [ANGLE_W-1:0] zi,
    output logic signed [XYI:0]       xo,
    output logic signed [XYI:0]       yo,
    output logic signed [ANGLE_W-1:0] zo);
    logic signed [XYI:0]       x, y, xs, ys;
    logic signed [ANGLE_W-1:0] z, a;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < NITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      a  = $signed(atan_lut(i));
      if (m == 1'b0) begin
        if (z[ANGLE_W-1]) begin
          x = x + ys; y = y - xs; z = z + a;
        end else begin
          x = x - ys; y = y + xs; z = z - a;
        end
      end else begin
        if (y[XYI]) begin
          x = x - ys; y = y + xs; z = z - a;
        end else begin
          x = x + ys; y = y - xs; z = z + a;
        end
      end
    end
    xo = x; yo = y; zo = z;
  endfunction

  // Accept one operand set, wait for the result, consume it.
  task automatic run_txn(
    input  logic                      m,
    input  logic signed [XYI:0]       x,
    input  logic signed [XYI:0]       y,
    input  logic signed [ANGLE_W-1:0] z,
    output logic signed [XYI:0]       rx,
    output logic signed [XYI:0]       ry,
    output logic signed [ANGLE_W-1:0] rz,
    output int                        lat);
    int n;
    @(negedge clk);
    in_mode = m; x_in = x; y_in = y; z_in = z;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < TMO) begin
      @(negedge clk); n++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid && lat < TMO);
    if (!out_valid) chk("result_timeout", 0, 1, 0);
    rx = x_out; ry = y_out; rz = z_out;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic                      mode;
    logic signed [XYI:0]       x;
    logic signed [XYI:0]       y;
    logic signed [ANGLE_W-1:0] z;
    longint                    ex, ey, ez;
    longint                    tol_xy, tol_z;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic signed [XYI:0]       rx, ry, mx, my;
    logic signed [ANGLE_W-1:0] rz, mz;
    logic signed [XYI:0]       bx[4], by[4];
    logic signed [ANGLE_W-1:0] bz[4];
    logic                      bm[4];
    int                        acc[4];
    int                        lat, n, bad;

    vt[0] = '{1'b0, 20'sd100000, 20'sd0, 32'sd0,
              164676, 0, 0, 24, 65536};
    vt[1] = '{1'b1, 20'sd100000, 20'sd100000, 32'sd0,
              232895, 0, 536870912, 24, 65536};
    vt[2] = '{1'b0, 20'sd100000, 20'sd0, -32'sd1073741824,
              0, -164676, 0, 24, 65536};
    vt[3] = '{1'b0, 20'sd0, 20'sd50000, 32'sd536870912,
              -58221, 58221, 0, 24, 65536};
    vt[4] = '{1'b1, 20'sd30000, -20'sd40000, 32'sd0,
              82338, 0, -633866735, 24, 65536};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1, 0);
    chk("rst_out_valid", longint'(out_valid), 0, 0);
    chk("rst_busy", longint'(busy), 0, 0);
    chk("rst_x", longint'(x_out), 0, 0);
    chk("rst_y", longint'(y_out), 0, 0);
    chk("rst_z", longint'(z_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      run_txn(vt[k].mode, vt[k].x, vt[k].y, vt[k].z,
              rx, ry, rz, lat);
      ref_model(vt[k].mode, vt[k].x, vt[k].y, vt[k].z,
                mx, my, mz);
      chk($sformatf("v%0d_lat", k), lat, NITER, 0);
      chk($sformatf("v%0d_x", k), rx, vt[k].ex, vt[k].tol_xy);
      chk($sformatf("v%0d_y", k), ry, vt[k].ey, vt[k].tol_xy);
      chk($sformatf("v%0d_z", k), rz, vt[k].ez, vt[k].tol_z);
      chk($sformatf("v%0d_xbit", k), rx, mx, 0);
      chk($sformatf("v%0d_ybit", k), ry, my, 0);
      chk($sformatf("v%0d_zbit", k), rz, mz, 0);
      chk($sformatf("v%0d_idle", k), longint'(in_ready), 1, 0);
    end

    // back-pressure in DONE with a stray in_valid pulse
    ref_model(1'b0, 20'sd100000, 20'sd0, 32'sd0, mx, my, mz);
    @(negedge clk);
    in_mode = 1'b0; x_in = 20'sd100000; y_in = '0; z_in = '0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < TMO) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_reach_done", longint'(out_valid), 1, 0);
    in_mode = 1'b1; x_in = 20'sd7; y_in = 20'sd9; z_in = 32'sd5;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", longint'(out_valid), 1, 0);
      chk("bp_in_ready", longint'(in_ready), 0, 0);
      chk("bp_x", x_out, mx, 0);
      chk("bp_y", y_out, my, 0);
      chk("bp_z", z_out, mz, 0);
      if (c == 1) in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_idle", longint'(in_ready), 1, 0);
    @(posedge clk); #1;
    chk("bp_no_stray_accept", longint'(busy), 0, 0);

    // back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 4; k++) begin
      bm[k] = k[0];
      bx[k] = 20'(30000 + 10000 * k);
      by[k] = 20'(k[0] ? 25000 : 0);
      bz[k] = 32'(k[0] ? 0 : 300000000 - 200000000 * k);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_mode = bm[0]; x_in = bx[0]; y_in = by[0]; z_in = bz[0];
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < TMO) begin
        @(negedge clk); n++;
      end
      if (!in_ready) chk("b2b_accept_timeout", 0, 1, 0);
      @(posedge clk); #1;
      acc[k] = cyc;
      if (k < 3) begin
        in_mode = bm[k+1]; x_in = bx[k+1];
        y_in = by[k+1]; z_in = bz[k+1];
      end else begin
        in_valid = 1'b0;
      end
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (!out_valid && n < TMO);
      ref_model(bm[k], bx[k], by[k], bz[k], mx, my, mz);
      chk($sformatf("b2b%0d_lat", k), n, NITER, 0);
      chk($sformatf("b2b%0d_x", k), x_out, mx, 0);
      chk($sformatf("b2b%0d_y", k), y_out, my, 0);
      chk($sformatf("b2b%0d_z", k), z_out, mz, 0);
      if (k > 0)
        chk($sformatf("b2b%0d_period", k),
            acc[k] - acc[k-1], NITER + 2, 0);
    end
    @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset in the middle of RUN
    @(negedge clk);
    in_mode = 1'b0; x_in = 20'sd100000; y_in = '0;
    z_in = 32'sd400000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mr_in_run", longint'(busy), 1, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", longint'(in_ready), 1, 0);
    chk("mr_out_valid", longint'(out_valid), 0, 0);
    chk("mr_busy", longint'(busy), 0, 0);
    chk("mr_x", longint'(x_out), 0, 0);
    chk("mr_y", longint'(y_out), 0, 0);
    chk("mr_z", longint'(z_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < NITER + 4; c++) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    chk("mr_discarded", bad, 0, 0);
    run_txn(1'b1, 20'sd60000, -20'sd20000, 32'sd0, rx, ry, rz, lat);
    ref_model(1'b1, 20'sd60000, -20'sd20000, 32'sd0, mx, my, mz);
    chk("mr_fresh_lat", lat, NITER, 0);
    chk("mr_fresh_x", rx, mx, 0);
    chk("mr_fresh_y", ry, my, 0);
    chk("mr_fresh_z", rz, mz, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
